// File: rtl/i2s_codec_master_if.sv
// Parallel sample bus between the record/play datapath and i2s_codec_master.
//
// Signals:
//   tx_left/tx_right  stereo pair to serialize onto AUD_ADCDAT
//   tx_valid          pair offered by the datapath
//   tx_ready          codec side holding register is empty
//   tx_underrun       one-clk pulse: a frame started with no pair held
//   rx_left/rx_right  last stereo pair deserialized from AUD_DACDAT
//   rx_valid          one-clk pulse: rx_left/rx_right just updated
//
// Modports:
//   master  datapath side (drives tx pair, consumes rx pair)
//   slave   codec serial port side (i2s_codec_master)
interface i2s_codec_master_if #(
  parameter int unsigned DATA_W = 16
) ();

  logic [DATA_W-1:0] tx_left;
  logic [DATA_W-1:0] tx_right;
  logic              tx_valid;
  logic              tx_ready;
  logic              tx_underrun;
  logic [DATA_W-1:0] rx_left;
  logic [DATA_W-1:0] rx_right;
  logic              rx_valid;

  modport master (
    output tx_left,
    output tx_right,
    output tx_valid,
    input  tx_ready,
    input  tx_underrun,
    input  rx_left,
    input  rx_right,
    input  rx_valid
  );

  modport slave (
    input  tx_left,
    input  tx_right,
    input  tx_valid,
    output tx_ready,
    output tx_underrun,
    output rx_left,
    output rx_right,
    output rx_valid
  );

endinterface

// File: rtl/i2s_codec_master.sv
// Clock/frame master and serial data endpoint for the audio codec serial port.
//
// Generates AUD_BCLK and a shared AUD_ADCLRCK/AUD_DACLRCK frame clock from clk, serializes
// the parallel stereo pair onto AUD_ADCDAT and deserializes AUD_DACDAT into a parallel pair.
// Default timing is left-justified, MSB first, MSB driven on the same BCLK fall as the LRCK
// edge. Define I2S_DELAY_EN for standard I2S timing (MSB one BCLK after the LRCK edge; then
// SLOT_BITS must be >= DATA_W+2).
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   rst          synchronous active-high reset
//   en           run enable; dropping it finishes the current frame then idles
//   bus          parallel sample bus (i2s_codec_master_if.slave)
//   AUD_BCLK     bit clock, half period BCLK_DIV clks
//   AUD_ADCLRCK  frame clock, high = left slot, low = right slot
//   AUD_DACLRCK  identical to AUD_ADCLRCK
//   AUD_ADCDAT   serial data out
//   AUD_DACDAT   serial data in, sampled on BCLK rise events
module i2s_codec_master #(
  parameter int unsigned BCLK_DIV  = 4,
  parameter int unsigned SLOT_BITS = 32,
  parameter int unsigned DATA_W    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  i2s_codec_master_if.slave        bus,
  output logic                     AUD_BCLK,
  output logic                     AUD_ADCLRCK,
  output logic                     AUD_DACLRCK,
  output logic                     AUD_ADCDAT,
  input  logic                     AUD_DACDAT
);

  localparam int unsigned DivW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int unsigned CntW = $clog2(SLOT_BITS);
`ifdef I2S_DELAY_EN
  localparam int unsigned Dly  = 1;
`else
  localparam int unsigned Dly  = 0;
`endif

  typedef enum logic [1:0] {StIdle, StRun, StStop} state_e;

  state_e            state_q, state_d;
  logic [DivW-1:0]   div_q, div_d;
  logic              bclk_q, bclk_d;
  logic              lrck_q, lrck_d;
  logic [CntW-1:0]   bit_q, bit_d;
  // Set once the first frame has started since leaving idle.
  logic              framed_q, framed_d;
  logic              adcdat_q, adcdat_d;
  logic              hold_full_q, hold_full_d;
  logic [DATA_W-1:0] hold_l_q, hold_l_d;
  logic [DATA_W-1:0] hold_r_q, hold_r_d;
  logic [DATA_W-1:0] tx_l_q, tx_l_d;
  logic [DATA_W-1:0] tx_r_q, tx_r_d;
  logic [DATA_W-1:0] rx_sh_l_q, rx_sh_l_d;
  logic [DATA_W-1:0] rx_sh_r_q, rx_sh_r_d;
  logic [DATA_W-1:0] rx_left_q, rx_left_d;
  logic [DATA_W-1:0] rx_right_q, rx_right_d;
  logic              rx_valid_q, rx_valid_d;
  logic              underrun_q, underrun_d;

  logic              active;
  logic              tick;
  logic              rise_ev;
  logic              fall_ev;
  logic              slot_wrap;
  logic              frame_edge;
  logic              stop_now;
  logic              frame_start;
  logic              accept;

  logic [DATA_W-1:0] load_l, load_r;
  logic [DATA_W-1:0] tx_word, tx_shift;
  logic [CntW-1:0]   tx_dbit, rx_dbit;
  logic              tx_in_data, rx_in_data;

  // Event decode
  assign active    = (state_q != StIdle);
  assign tick      = active && (div_q == DivW'(BCLK_DIV - 1));
  assign rise_ev   = tick && !bclk_q;
  assign fall_ev   = tick && bclk_q;
  assign slot_wrap = (bit_q == CntW'(SLOT_BITS - 1));
  // Fall event that would begin a left slot: very first fall, or wrap out of the right slot.
  assign frame_edge  = fall_ev && (!framed_q || (slot_wrap && !lrck_q));
  assign stop_now    = frame_edge && (state_q == StStop) && !en;
  assign frame_start = frame_edge && !stop_now;
  assign accept      = bus.tx_valid && !hold_full_q;

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (en) state_d = StRun;
      StRun:  if (!en) state_d = StStop;
      StStop: begin
        if (en)            state_d = StRun;
        else if (stop_now) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Bit clock divider, frame clock and bit counter
  always_comb begin
    div_d    = div_q;
    bclk_d   = bclk_q;
    lrck_d   = lrck_q;
    bit_d    = bit_q;
    framed_d = framed_q;
    if (!active || stop_now) begin
      div_d    = '0;
      bclk_d   = 1'b0;
      lrck_d   = 1'b0;
      bit_d    = '0;
      framed_d = 1'b0;
    end else begin
      if (tick) begin
        div_d  = '0;
        bclk_d = ~bclk_q;
      end else begin
        div_d = div_q + DivW'(1);
      end
      if (fall_ev) begin
        if (!framed_q) begin
          framed_d = 1'b1;
          lrck_d   = 1'b1;
          bit_d    = '0;
        end else if (slot_wrap) begin
          lrck_d = ~lrck_q;
          bit_d  = '0;
        end else begin
          bit_d = bit_q + CntW'(1);
        end
      end
    end
  end

  // Transmit: holding register, frame-start load and serializer
  always_comb begin
    hold_full_d = hold_full_q;
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    tx_l_d      = tx_l_q;
    tx_r_d      = tx_r_q;
    underrun_d  = 1'b0;
    adcdat_d    = adcdat_q;
    load_l      = '0;
    load_r      = '0;

    if (frame_start) begin
      // An old held pair wins; a pair offered into an empty holding register goes straight
      // to the shifters so it does not count as an underrun.
      if (hold_full_q) begin
        load_l      = hold_l_q;
        load_r      = hold_r_q;
        hold_full_d = 1'b0;
      end else if (accept) begin
        load_l = bus.tx_left;
        load_r = bus.tx_right;
      end else begin
        underrun_d = 1'b1;
      end
      tx_l_d = load_l;
      tx_r_d = load_r;
    end else if (accept) begin
      hold_full_d = 1'b1;
      hold_l_d    = bus.tx_left;
      hold_r_d    = bus.tx_right;
    end

    // Bit position within the sample for the bit about to be driven.
    tx_dbit    = bit_d - CntW'(Dly);
    tx_in_data = ((Dly == 0) || (bit_d != '0)) && (tx_dbit < CntW'(DATA_W));
    tx_word    = lrck_d ? tx_l_d : tx_r_d;
    tx_shift   = tx_word << tx_dbit;

    if (stop_now) begin
      adcdat_d = 1'b0;
    end else if (fall_ev) begin
      adcdat_d = tx_in_data & tx_shift[DATA_W-1];
    end
  end

  // Receive: sample on rise events, publish both channels after the right slot LSB
  always_comb begin
    rx_sh_l_d  = rx_sh_l_q;
    rx_sh_r_d  = rx_sh_r_q;
    rx_left_d  = rx_left_q;
    rx_right_d = rx_right_q;
    rx_valid_d = 1'b0;

    rx_dbit    = bit_q - CntW'(Dly);
    rx_in_data = ((Dly == 0) || (bit_q != '0)) && (rx_dbit < CntW'(DATA_W));

    if (rise_ev && framed_q && rx_in_data) begin
      if (lrck_q) begin
        rx_sh_l_d = {rx_sh_l_q[DATA_W-2:0], AUD_DACDAT};
      end else begin
        rx_sh_r_d = {rx_sh_r_q[DATA_W-2:0], AUD_DACDAT};
        if (rx_dbit == CntW'(DATA_W - 1)) begin
          rx_left_d  = rx_sh_l_q;
          rx_right_d = rx_sh_r_d;
          rx_valid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      div_q       <= '0;
      bclk_q      <= 1'b0;
      lrck_q      <= 1'b0;
      bit_q       <= '0;
      framed_q    <= 1'b0;
      adcdat_q    <= 1'b0;
      hold_full_q <= 1'b0;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      tx_l_q      <= '0;
      tx_r_q      <= '0;
      rx_sh_l_q   <= '0;
      rx_sh_r_q   <= '0;
      rx_left_q   <= '0;
      rx_right_q  <= '0;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bclk_q      <= bclk_d;
      lrck_q      <= lrck_d;
      bit_q       <= bit_d;
      framed_q    <= framed_d;
      adcdat_q    <= adcdat_d;
      hold_full_q <= hold_full_d;
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      tx_l_q      <= tx_l_d;
      tx_r_q      <= tx_r_d;
      rx_sh_l_q   <= rx_sh_l_d;
      rx_sh_r_q   <= rx_sh_r_d;
      rx_left_q   <= rx_left_d;
      rx_right_q  <= rx_right_d;
      rx_valid_q  <= rx_valid_d;
      underrun_q  <= underrun_d;
    end
  end

  assign bus.tx_ready    = !hold_full_q;
  assign bus.tx_underrun = underrun_q;
  assign bus.rx_left     = rx_left_q;
  assign bus.rx_right    = rx_right_q;
  assign bus.rx_valid    = rx_valid_q;

  assign AUD_BCLK    = bclk_q;
  assign AUD_ADCLRCK = lrck_q;
  assign AUD_DACLRCK = lrck_q;
  assign AUD_ADCDAT  = adcdat_q;

endmodule

// File: tb/tb_i2s_codec_master.sv
// Directed bench for i2s_codec_master (left-justified build, BCLK_DIV=4, SLOT_BITS=32,
// DATA_W=16). AUD_DACDAT is looped back from AUD_ADCDAT.
module tb_i2s_codec_master;

  localparam int unsigned BclkDiv  = 4;
  localparam int unsigned SlotBits = 32;
  localparam int unsigned DataW    = 16;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic aud_bclk;
  logic aud_adclrck;
  logic aud_daclrck;
  logic aud_adcdat;
  logic aud_dacdat;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  i2s_codec_master_if #(.DATA_W(DataW)) bus ();

  i2s_codec_master #(
    .BCLK_DIV (BclkDiv),
    .SLOT_BITS(SlotBits),
    .DATA_W   (DataW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .bus        (bus),
    .AUD_BCLK   (aud_bclk),
    .AUD_ADCLRCK(aud_adclrck),
    .AUD_DACLRCK(aud_daclrck),
    .AUD_ADCDAT (aud_adcdat),
    .AUD_DACDAT (aud_dacdat)
  );

  assign aud_dacdat = aud_adcdat;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_bclk"},     64'(aud_bclk), 64'd0);
    check({tag, "_adclrck"},  64'(aud_adclrck), 64'd0);
    check({tag, "_daclrck"},  64'(aud_daclrck), 64'd0);
    check({tag, "_adcdat"},   64'(aud_adcdat), 64'd0);
    check({tag, "_tx_ready"}, 64'(bus.tx_ready), 64'd1);
    check({tag, "_underrun"}, 64'(bus.tx_underrun), 64'd0);
    check({tag, "_rx_valid"}, 64'(bus.rx_valid), 64'd0);
    check({tag, "_rx_left"},  64'(bus.rx_left), 64'd0);
    check({tag, "_rx_right"}, 64'(bus.rx_right), 64'd0);
  endtask

  // Waits (bounded) for an LRCK rise; returns at that sample.
  task automatic wait_frame_start(output bit found, output logic rdy_before,
                                  output logic rdy_at, output logic bclk_before,
                                  output logic bclk_at);
    logic pl, pr, pb;
    found = 0; rdy_before = 1'bx; rdy_at = 1'bx; bclk_before = 1'bx; bclk_at = 1'bx;
    pl = aud_adclrck; pr = bus.tx_ready; pb = aud_bclk;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (aud_adclrck && !pl) begin
        found = 1; rdy_before = pr; rdy_at = bus.tx_ready; bclk_before = pb; bclk_at = aud_bclk;
      end
      pl = aud_adclrck; pr = bus.tx_ready; pb = aud_bclk;
    end
  endtask

  // Entered at the frame-start sample; ends at the next frame-start sample (512 clks later).
  task automatic capture_frame(input int fno, input bit give, input logic [15:0] l,
                               input logic [15:0] r, input logic [63:0] exp_bits,
                               input logic [15:0] exp_l, input logic [15:0] exp_r,
                               input int exp_und);
    logic [63:0] bits;
    logic [15:0] vl, vr;
    int hi, rises, first_rise, nvalid, nund;
    logic pb, lr_match;
    string t;
    t = $sformatf("f%0d", fno);
    bits = '0; vl = '0; vr = '0; hi = 1; rises = 0; first_rise = -1; nvalid = 0;
    nund = bus.tx_underrun ? 1 : 0;
    lr_match = (aud_daclrck === aud_adclrck);
    pb = aud_bclk;
    if (give) begin
      bus.tx_left = l; bus.tx_right = r; bus.tx_valid = 1'b1;
    end
    for (int i = 1; i < 512; i++) begin
      @(negedge clk);
      bus.tx_valid = 1'b0;
      if (aud_adclrck) hi++;
      if (aud_daclrck !== aud_adclrck) lr_match = 1'b0;
      if (aud_bclk && !pb) begin
        if (rises == 0) first_rise = i;
        rises++;
        bits = {bits[62:0], aud_adcdat};
      end
      if (bus.tx_underrun) nund++;
      if (bus.rx_valid) begin
        nvalid++; vl = bus.rx_left; vr = bus.rx_right;
      end
      pb = aud_bclk;
    end
    @(negedge clk);
    check({t, "_adcdat_bits"}, bits, exp_bits);
    check({t, "_lrck_high_clks"}, 64'(hi), 64'd256);
    check({t, "_lrck_period"}, 64'(aud_adclrck), 64'd1);
    check({t, "_daclrck_eq"}, 64'(lr_match), 64'd1);
    check({t, "_bclk_rises"}, 64'(rises), 64'd64);
    check({t, "_bclk_first_rise"}, 64'(first_rise), 64'd4);
    check({t, "_rx_valid_pulses"}, 64'(nvalid), 64'd1);
    check({t, "_rx_left"}, 64'(vl), 64'(exp_l));
    check({t, "_rx_right"}, 64'(vr), 64'(exp_r));
    check({t, "_underrun_pulses"}, 64'(nund), 64'(exp_und));
  endtask

  initial begin
    bit found;
    logic rb, ra, bb, ba;
    int toggles, last_act, nv;
    logic pb, pl;

    rst = 1'b1; en = 1'b0;
    bus.tx_valid = 1'b0; bus.tx_left = '0; bus.tx_right = '0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;

    // Idle: no clock activity, holding register open.
    toggles = 0; pb = aud_bclk; pl = aud_adclrck;
    repeat (100) begin
      @(negedge clk);
      if (aud_bclk !== pb || aud_adclrck !== pl) toggles++;
      pb = aud_bclk; pl = aud_adclrck;
    end
    check("idle_toggles", 64'(toggles), 64'd0);
    check("idle_tx_ready", 64'(bus.tx_ready), 64'd1);

    // Pair accepted in idle; a second offer while full is refused.
    bus.tx_left = 16'hA5C3; bus.tx_right = 16'h0F01; bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    check("hold_full_ready", 64'(bus.tx_ready), 64'd0);
    bus.tx_left = 16'h1111; bus.tx_right = 16'h2222; bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    check("hold_refuse_ready", 64'(bus.tx_ready), 64'd0);
    check("idle_adcdat", 64'(aud_adcdat), 64'd0);

    en = 1'b1;
    wait_frame_start(found, rb, ra, bb, ba);
    check("start_found", 64'(found), 64'd1);
    check("start_ready_before", 64'(rb), 64'd0);
    check("start_ready_at", 64'(ra), 64'd1);
    check("start_bclk_before", 64'(bb), 64'd1);
    check("start_bclk_at", 64'(ba), 64'd0);

    // Frame 1: held A5C3/0F01, offer 8001/7FFE for frame 2. Frame 3 underruns.
    capture_frame(1, 1'b1, 16'h8001, 16'h7FFE, 64'hA5C3_0000_0F01_0000,
                  16'hA5C3, 16'h0F01, 0);
    capture_frame(2, 1'b0, 16'h0000, 16'h0000, 64'h8001_0000_7FFE_0000,
                  16'h8001, 16'h7FFE, 0);
    capture_frame(3, 1'b0, 16'h0000, 16'h0000, 64'h0, 16'h0000, 16'h0000, 1);

    // Stop mid left slot: frame runs out, then clocks park low.
    repeat (40) @(negedge clk);
    en = 1'b0;
    last_act = 0; nv = 0;
    for (int i = 41; i <= 700; i++) begin
      @(negedge clk);
      if (aud_bclk || aud_adclrck) last_act = i;
      if (bus.rx_valid) nv++;
    end
    check("stop_last_active", 64'(last_act), 64'd511);
    check("stop_rx_valid", 64'(nv), 64'd1);
    check("stop_adcdat", 64'(aud_adcdat), 64'd0);

    // Reset during bit 5 of the left slot with a pair held.
    en = 1'b1;
    wait_frame_start(found, rb, ra, bb, ba);
    check("rst_start_found", 64'(found), 64'd1);
    bus.tx_left = 16'h1234; bus.tx_right = 16'h5678; bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    check("rst_hold_ready", 64'(bus.tx_ready), 64'd0);
    repeat (43) @(negedge clk);
    check("rst_point_bclk", 64'(aud_bclk), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_values("midrst");
    @(negedge clk);
    rst = 1'b0; en = 1'b0;
    toggles = 0; nv = 0; pb = aud_bclk;
    repeat (400) begin
      @(negedge clk);
      if (aud_bclk !== pb) toggles++;
      if (bus.rx_valid) nv++;
      pb = aud_bclk;
    end
    check("post_rst_toggles", 64'(toggles), 64'd0);
    check("post_rst_rx_valid", 64'(nv), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2s_codec_master.md
Name: i2s_codec_master

Overview:
- Clock/frame master and serial data endpoint for the audio codec serial port.
- Generates AUD_BCLK and the shared AUD_ADCLRCK/AUD_DACLRCK frame clock from the system clock.
- Serializes parallel stereo samples onto AUD_ADCDAT and deserializes AUD_DACDAT into parallel stereo samples.
- Used as the bus master/emulator that the record/play datapath attaches to; left-justified, MSB first.

Parameters:
- BCLK_DIV, 4, AUD_BCLK half-period in clk cycles (>=1).
- SLOT_BITS, 32, BCLK periods per channel slot (>= DATA_W+1).
- DATA_W, 16, sample width per channel.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- en  input  1  run enable.
- tx_left  input  DATA_W  left sample to send on AUD_ADCDAT.
- tx_right  input  DATA_W  right sample to send on AUD_ADCDAT.
- tx_valid  input  1  tx pair valid.
- tx_ready  output  1  holding register empty; pair accepted when tx_valid && tx_ready.
- tx_underrun  output  1  one-clk pulse: frame started with no pair held.
- rx_left  output  DATA_W  last received left sample from AUD_DACDAT.
- rx_right  output  DATA_W  last received right sample.
- rx_valid  output  1  one-clk pulse: rx_left/rx_right updated.
- AUD_BCLK  output  1  bit clock.
- AUD_ADCLRCK  output  1  frame clock; high = left slot, low = right slot.
- AUD_DACLRCK  output  1  identical to AUD_ADCLRCK.
- AUD_ADCDAT  output  1  serial data out.
- AUD_DACDAT  input  1  serial data in.

Behaviour:
- Reset values: AUD_BCLK=0, LRCKs=0, AUD_ADCDAT=0, tx_ready=1, tx_underrun=0, rx_valid=0, rx_left=rx_right=0. All counters and shift/holding registers are cleared.
- A reset asserted mid-frame aborts the frame in that cycle. No rx_valid pulse is produced for the partial frame.
- States: IDLE, RUN, STOP.
  - IDLE -> RUN when en=1.
  - RUN -> STOP when en=0.
  - STOP -> IDLE at the end of the current frame, i.e. the last falling event of the right slot.
  - STOP -> RUN if en reasserts before that point.
- In IDLE, AUD_BCLK=0, LRCK=0 and AUD_ADCDAT=0. The holding register still accepts a pair.
- Divider: div_cnt counts 0..BCLK_DIV-1 in RUN/STOP. On the terminal count AUD_BCLK toggles.
  - A 0->1 toggle is a "rise event"; a 1->0 toggle is a "fall event".
  - BCLK period is 2*BCLK_DIV clks. A frame is 2*SLOT_BITS BCLK periods.
- First fall event after leaving IDLE: LRCK goes 1 (left slot start), bit_cnt=0, and the frame-start load occurs.
- Fall event, general case: bit_cnt increments. At SLOT_BITS-1 it wraps to 0 and LRCK toggles; a 0->1 toggle is a frame start.
- Frame-start load:
  - If the holding register is full, load tx_left/tx_right into the shift registers and clear holding (tx_ready=1 next cycle).
  - Otherwise load zeros and pulse tx_underrun.
- AUD_ADCDAT updates only on fall events. It carries bit DATA_W-1-bit_cnt of the current channel for bit_cnt<DATA_W, and 0 otherwise. The MSB is driven on the same fall event as the LRCK edge.
- Rise events: for bit_cnt<DATA_W, shift AUD_DACDAT MSB-first into the rx shift register of the current channel.
- On the rise event with bit_cnt=DATA_W-1 in the right slot:
  - rx_left and rx_right are updated together.
  - rx_valid pulses for that clk.
- Simultaneous accept and frame-start load in the same clk: the load uses the old holding contents (if full). The new pair is accepted only if holding was empty, in which case the pair is written directly to the shift registers with no underrun.
- While holding is full, tx_ready=0.

Optional Feature:
- I2S_DELAY_EN defined: standard I2S timing.
  - The MSB is driven on the fall event one BCLK after the LRCK edge, so data occupies bit_cnt 1..DATA_W. Rx sampling shifts by one in the same way.
  - rx_valid occurs at bit_cnt=DATA_W of the right slot.
  - Requires SLOT_BITS >= DATA_W+2.
- Not defined: left-justified timing as in Behaviour.

Test Plan:
- Reset/idle (BCLK_DIV=4, SLOT_BITS=32, DATA_W=16): rst 3 clks, en=0 -> all outputs at reset values, tx_ready=1, no BCLK toggles for 100 clks.
- Clocking: en=1 -> BCLK period 8 clks, LRCK period 512 clks, LRCK high 256 clks. LRCK edges coincide with BCLK falls.
- TX: hold pair L=16'hA5C3, R=16'h0F01 before start -> AUD_ADCDAT during left slot is 1010010111000011 then 16 zeros, right slot 0000111100000001. tx_ready rises at the frame-start clk.
- RX loopback (AUD_DACDAT tied to AUD_ADCDAT), pair L=16'h8001, R=16'h7FFE -> rx_valid one pulse per frame with rx_left=16'h8001, rx_right=16'h7FFE.
- Underrun: no tx_valid for the second frame -> tx_underrun pulse at frame start and all-zero AUD_ADCDAT for that frame.
- Stop/reset: en=0 mid-left-slot -> frame completes, then BCLK/LRCK held 0. Separately, rst at bit_cnt=5 -> reset values next clk and no rx_valid.
